// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: one outstanding RD/WR request, per-bank open-row tracking, refresh sequencing.
// Optional macro AUTO_REFRESH_EN adds an internal TREFI interval timer that raises refresh requests.
module ddr_cmd_scheduler #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 1,
    parameter int BGWIDTH       = (BANKGROUPS > 1) ? $clog2(BANKGROUPS) : 1,
    parameter int BANKSPERGROUP = 8,
    parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
    parameter int COLWIDTH      = 10,
    parameter int TRCD          = 4,
    parameter int TRP           = 4,
    parameter int TRFC          = 16,
    parameter int TREFI         = 1024
) (
    input  logic                 ck_t,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 ref_req,
    output logic                 ref_done,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] addr,
    output logic [BAWIDTH-1:0]   ba,
    output logic [BGWIDTH-1:0]   bg,
    output logic [3:0]           dbg_state
);

    localparam int IDXW   = BGWIDTH + BAWIDTH;
    localparam int NBANKS = 1 << IDXW;
    localparam int TMAX_A = (TRCD > TRP) ? TRCD : TRP;
    localparam int TMAX   = (TMAX_A > TRFC) ? TMAX_A : TRFC;
    localparam int CNTW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [3:0] CODE_PRE = 4'd3;
    localparam logic [3:0] CODE_RD  = 4'd4;
    localparam logic [3:0] CODE_REF = 4'd5;
    localparam logic [3:0] CODE_WR  = 4'd6;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PRE       = 4'd1,
        TRP_WAIT  = 4'd2,
        ACT       = 4'd3,
        TRCD_WAIT = 4'd4,
        CAS       = 4'd5,
        PRA       = 4'd6,
        REF       = 4'd7,
        TRFC_WAIT = 4'd8
    } state_t;

    state_t state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic            ref_seq;
    logic            ref_pend;
    logic            ref_set;
    logic            cke_q;
    logic            accept;

    logic                 write_q;
    logic [BGWIDTH-1:0]   bg_q;
    logic [BAWIDTH-1:0]   ba_q;
    logic [ADDRWIDTH-1:0] row_q;
    logic [COLWIDTH-1:0]  col_q;

    logic [NBANKS-1:0]    bank_open;
    logic [ADDRWIDTH-1:0] bank_row [NBANKS];
    logic [IDXW-1:0]      req_idx, idx_q;

    logic                 cmd_cs_n, cmd_act_n;
    logic [ADDRWIDTH-1:0] cmd_addr;
    logic [BAWIDTH-1:0]   cmd_ba;
    logic [BGWIDTH-1:0]   cmd_bg;

    assign req_idx   = {req_bg, req_ba};
    assign idx_q     = {bg_q, ba_q};
    assign req_ready = cke_q && (state == IDLE) && !ref_pend;
    assign accept    = req_valid && req_ready;
    assign cke       = cke_q;
    assign dbg_state = state;

`ifdef AUTO_REFRESH_EN
    localparam int REFIW = (TREFI > 1) ? $clog2(TREFI) : 1;
    logic [REFIW-1:0] refi_cnt;
    logic             refi_tick;

    assign refi_tick = (refi_cnt == REFIW'(TREFI - 1));
    assign ref_set   = ref_req | refi_tick;

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n)       refi_cnt <= '0;
        else if (refi_tick) refi_cnt <= '0;
        else                refi_cnt <= refi_cnt + REFIW'(1);
    end
`else
    assign ref_set = ref_req;
`endif

    // Command states load their spacing count on entry so the following
    // command lands exactly N cycles later; REF loads TRFC on exit instead.
    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? cnt - CNTW'(1) : cnt;
        case (state)
            IDLE: begin
                if (cke_q) begin
                    if (ref_pend) begin
                        state_next = (|bank_open) ? PRA : REF;
                    end else if (req_valid) begin
                        if (!bank_open[req_idx])                state_next = ACT;
                        else if (bank_row[req_idx] == req_row) state_next = CAS;
                        else                                   state_next = PRE;
                    end
                end
            end
            PRE, PRA:  state_next = (cnt != '0) ? TRP_WAIT : ((state == PRA) ? REF : ACT);
            TRP_WAIT:  if (cnt == '0) state_next = ref_seq ? REF : ACT;
            ACT:       state_next = (cnt != '0) ? TRCD_WAIT : CAS;
            TRCD_WAIT: if (cnt == '0) state_next = CAS;
            CAS:       state_next = IDLE;
            REF:       state_next = TRFC_WAIT;
            TRFC_WAIT: if (cnt == '0) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (state_next != state) begin
            case (state_next)
                ACT:       cnt_next = CNTW'(TRCD - 1);
                PRE, PRA:  cnt_next = CNTW'(TRP - 1);
                TRFC_WAIT: cnt_next = CNTW'(TRFC - 1);
                default:   ;
            endcase
        end
    end

    always_comb begin
        cmd_cs_n  = 1'b1;
        cmd_act_n = 1'b1;
        cmd_addr  = '0;
        cmd_ba    = '0;
        cmd_bg    = '0;
        case (state)
            ACT: begin
                cmd_cs_n  = 1'b0;
                cmd_act_n = 1'b0;
                cmd_addr  = row_q;
                cmd_ba    = ba_q;
                cmd_bg    = bg_q;
            end
            PRE: begin
                cmd_cs_n = 1'b0;
                cmd_addr[ADDRWIDTH-1 -: 4] = CODE_PRE;
                cmd_ba   = ba_q;
                cmd_bg   = bg_q;
            end
            PRA: begin
                cmd_cs_n = 1'b0;
                cmd_addr[ADDRWIDTH-1 -: 4] = CODE_PRE;
                cmd_addr[10] = 1'b1;
            end
            CAS: begin
                cmd_cs_n = 1'b0;
                cmd_addr[ADDRWIDTH-1 -: 4] = write_q ? CODE_WR : CODE_RD;
                cmd_addr[COLWIDTH-1:0]     = col_q;
                cmd_ba   = ba_q;
                cmd_bg   = bg_q;
            end
            REF: begin
                cmd_cs_n = 1'b0;
                cmd_addr[ADDRWIDTH-1 -: 4] = CODE_REF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_seq   <= 1'b0;
            ref_pend  <= 1'b0;
            cke_q     <= 1'b0;
            write_q   <= 1'b0;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            bank_open <= '0;
            for (int i = 0; i < NBANKS; i++) bank_row[i] <= '0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            addr      <= '0;
            ba        <= '0;
            bg        <= '0;
            ref_done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cke_q <= 1'b1;
            if (state == PRA)      ref_seq <= 1'b1;
            else if (state == PRE) ref_seq <= 1'b0;
            // A request arriving while refresh is already pending is simply absorbed.
            if (state == REF)  ref_pend <= 1'b0;
            else if (ref_set)  ref_pend <= 1'b1;
            if (accept) begin
                write_q <= req_write;
                bg_q    <= req_bg;
                ba_q    <= req_ba;
                row_q   <= req_row;
                col_q   <= req_col;
            end
            case (state)
                ACT: begin
                    bank_open[idx_q] <= 1'b1;
                    bank_row[idx_q]  <= row_q;
                end
                PRE:      bank_open[idx_q] <= 1'b0;
                PRA, REF: bank_open <= '0;
                default:  ;
            endcase
            cs_n     <= cmd_cs_n;
            act_n    <= cmd_act_n;
            addr     <= cmd_addr;
            ba       <= cmd_ba;
            bg       <= cmd_bg;
            ref_done <= (state == REF);
        end
    end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: bank hit/miss/closed timing, refresh ordering, reset recovery.
module tb_ddr_cmd_scheduler;

    logic        ck_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [0:0]  req_bg = '0;
    logic [2:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        ref_req = 1'b0;
    logic        ref_done;
    logic        cke, cs_n, act_n;
    logic [16:0] addr;
    logic [2:0]  ba;
    logic [0:0]  bg;
    logic [3:0]  dbg_state;

    int n_checks = 0;
    int n_fail = 0;

`ifdef AUTO_REFRESH_EN
    localparam int EXP_AUTO_REF = 2;
`else
    localparam int EXP_AUTO_REF = 0;
`endif

    ddr_cmd_scheduler dut (
        .ck_t(ck_t), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col),
        .ref_req(ref_req), .ref_done(ref_done),
        .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .addr(addr), .ba(ba), .bg(bg), .dbg_state(dbg_state)
    );

    always #5 ck_t = ~ck_t;

    task automatic tick();
        @(posedge ck_t);
        #1;
    endtask

    task automatic send_req(input logic w, input logic [2:0] bank, input logic [16:0] row, input logic [9:0] col);
        req_write = w; req_bg = '0; req_ba = bank; req_row = row; req_col = col; req_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (req_ready === 1'b1) begin
                tick();
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    // Cycles until the next non-NOP command on the pins, -1 if none within the budget.
    task automatic wait_cmd(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (cs_n === 1'b0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (cke !== 1'b0) begin n_fail++; $display("FAIL reset_cke: got %b want 0", cke); end
        n_checks++; if ({cs_n, act_n} !== 2'b11) begin n_fail++; $display("FAIL reset_nop: cs_n/act_n got %b want 11", {cs_n, act_n}); end
        n_checks++; if ({addr, ba, bg} !== 21'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", {addr, ba, bg}); end
        n_checks++; if ({req_ready, ref_done} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req_ready, ref_done}); end
        n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset_n = 1'b1;
        tick();
        n_checks++; if ({cke, req_ready} !== 2'b11) begin n_fail++; $display("FAIL release: cke/ready got %b want 11", {cke, req_ready}); end
    endtask

    task automatic test_closed_read();
        int c;
        send_req(1'b0, 3'd0, 17'd5, 10'd7);
        wait_cmd(c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL closed_act_lat: got %0d want 1", c); end
        n_checks++; if ({act_n, addr, ba} !== {1'b0, 17'd5, 3'd0}) begin n_fail++; $display("FAIL closed_act: got %b/%h/%0d want 0/00005/0", act_n, addr, ba); end
        wait_cmd(c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL closed_rd_lat: got %0d want 4", c); end
        n_checks++; if ({act_n, addr} !== {1'b1, 17'h08007}) begin n_fail++; $display("FAIL closed_rd: got %b/%h want 1/08007", act_n, addr); end
    endtask

    task automatic test_row_hit();
        int c;
        send_req(1'b0, 3'd0, 17'd5, 10'd9);
        wait_cmd(c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL hit_rd_lat: got %0d want 1", c); end
        n_checks++; if ({act_n, addr} !== {1'b1, 17'h08009}) begin n_fail++; $display("FAIL hit_rd: got %b/%h want 1/08009", act_n, addr); end
    endtask

    task automatic test_row_miss();
        int c;
        send_req(1'b1, 3'd0, 17'd6, 10'd3);
        wait_cmd(c);
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL miss_pre_lat: got %0d want 1", c); end
        n_checks++; if ({act_n, addr} !== {1'b1, 17'h06000}) begin n_fail++; $display("FAIL miss_pre: got %b/%h want 1/06000", act_n, addr); end
        wait_cmd(c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL miss_act_lat: got %0d want 4", c); end
        n_checks++; if ({act_n, addr} !== {1'b0, 17'd6}) begin n_fail++; $display("FAIL miss_act: got %b/%h want 0/00006", act_n, addr); end
        wait_cmd(c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL miss_wr_lat: got %0d want 4", c); end
        n_checks++; if ({act_n, addr} !== {1'b1, 17'h0C003}) begin n_fail++; $display("FAIL miss_wr: got %b/%h want 1/0C003", act_n, addr); end
    endtask

    task automatic test_refresh();
        int c;
        ref_req = 1'b1;
        tick();
        ref_req = 1'b0;
        req_write = 1'b0; req_bg = '0; req_ba = 3'd0; req_row = 17'd5; req_col = 10'd4; req_valid = 1'b1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ref_blocks_ready: got %b want 0", req_ready); end
        wait_cmd(c);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL pra_lat: got %0d want 2", c); end
        n_checks++; if ({act_n, addr} !== {1'b1, 17'h06400}) begin n_fail++; $display("FAIL pra: got %b/%h want 1/06400", act_n, addr); end
        wait_cmd(c);
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL ref_lat: got %0d want 4", c); end
        n_checks++; if ({addr, ref_done} !== {17'h0A000, 1'b1}) begin n_fail++; $display("FAIL ref_cmd: got %h/%b want 0A000/1", addr, ref_done); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if (ref_done !== 1'b0) begin n_fail++; $display("FAIL ref_done_pulse: got %b want 0", ref_done); end
            end
            n_checks++; if (req_ready !== (k == 16)) begin n_fail++; $display("FAIL trfc_ready k=%0d: got %b want %b", k, req_ready, (k == 16)); end
        end
        tick();
        req_valid = 1'b0;
        wait_cmd(c);
        n_checks++; if ({c, act_n, addr} !== {32'sd1, 1'b0, 17'd5}) begin n_fail++; $display("FAIL post_ref_act: got %0d/%b/%h want 1/0/00005", c, act_n, addr); end
        wait_cmd(c);
        n_checks++; if ({c, addr} !== {32'sd4, 17'h08004}) begin n_fail++; $display("FAIL post_ref_rd: got %0d/%h want 4/08004", c, addr); end
    endtask

    task automatic test_ref_during_request();
        int c;
        send_req(1'b0, 3'd0, 17'd7, 10'd2);
        ref_req = 1'b1;
        tick();
        ref_req = 1'b0;
        n_checks++; if ({cs_n, act_n, addr} !== {2'b01, 17'h06000}) begin n_fail++; $display("FAIL inflight_pre: got %b%b/%h want 01/06000", cs_n, act_n, addr); end
        wait_cmd(c);
        n_checks++; if ({c, act_n, addr} !== {32'sd4, 1'b0, 17'd7}) begin n_fail++; $display("FAIL inflight_act: got %0d/%b/%h want 4/0/00007", c, act_n, addr); end
        wait_cmd(c);
        n_checks++; if ({c, addr} !== {32'sd4, 17'h08002}) begin n_fail++; $display("FAIL inflight_rd: got %0d/%h want 4/08002", c, addr); end
        wait_cmd(c);
        n_checks++; if ({c, addr} !== {32'sd2, 17'h06400}) begin n_fail++; $display("FAIL inflight_pra: got %0d/%h want 2/06400", c, addr); end
        wait_cmd(c);
        n_checks++; if ({c, addr} !== {32'sd4, 17'h0A000}) begin n_fail++; $display("FAIL inflight_ref: got %0d/%h want 4/0A000", c, addr); end
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        int c;
        send_req(1'b0, 3'd2, 17'd9, 10'd1);
        wait_cmd(c);
        n_checks++; if ({c, act_n, addr, ba} !== {32'sd1, 1'b0, 17'd9, 3'd2}) begin n_fail++; $display("FAIL mid_act: got %0d/%b/%h/%0d want 1/0/00009/2", c, act_n, addr, ba); end
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++; if ({cke, cs_n, act_n, req_ready} !== 4'b0110) begin n_fail++; $display("FAIL mid_reset_pins: got %b want 0110", {cke, cs_n, act_n, req_ready}); end
        tick();
        n_checks++; if ({cs_n, addr, dbg_state} !== {1'b1, 17'h0, 4'd0}) begin n_fail++; $display("FAIL mid_reset_hold: got %b/%h/%0d want 1/00000/0", cs_n, addr, dbg_state); end
        reset_n = 1'b1;
        tick();
        n_checks++; if ({cke, req_ready} !== 2'b11) begin n_fail++; $display("FAIL mid_release: got %b want 11", {cke, req_ready}); end
        send_req(1'b0, 3'd2, 17'd9, 10'd1);
        wait_cmd(c);
        n_checks++; if ({c, act_n, addr} !== {32'sd1, 1'b0, 17'd9}) begin n_fail++; $display("FAIL table_cleared_act: got %0d/%b/%h want 1/0/00009", c, act_n, addr); end
        wait_cmd(c);
        n_checks++; if ({c, addr, ba} !== {32'sd4, 17'h08001, 3'd2}) begin n_fail++; $display("FAIL table_cleared_rd: got %0d/%h/%0d want 4/08001/2", c, addr, ba); end
    endtask

    task automatic test_auto_refresh();
        int n_ref;
        n_ref = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (cs_n === 1'b0 && addr === 17'h0A000) n_ref++;
        end
        n_checks++; if (n_ref !== EXP_AUTO_REF) begin n_fail++; $display("FAIL auto_refresh_count: got %0d want %0d", n_ref, EXP_AUTO_REF); end
    endtask

    initial begin
        test_reset();
        test_closed_read();
        test_row_hit();
        test_row_miss();
        test_refresh();
        test_ref_during_request();
        test_reset_mid();
        test_auto_refresh();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_scheduler.md
DDR_CMD_SCHEDULER -- requirements
Module: ddr_cmd_scheduler

Interface
REQ-001 SHALL have parameters: ADDRWIDTH, default 17, command address bus width.
REQ-002 SHALL have parameters: BANKGROUPS 1, BGWIDTH $clog2(BANKGROUPS) (min 1), BANKSPERGROUP 8, BAWIDTH $clog2(BANKSPERGROUP), COLWIDTH 10.
REQ-003 SHALL have parameters: TRCD 4, TRP 4, TRFC 16, TREFI 1024, all in clock cycles, each >=1.
REQ-004 SHALL have one clock and one reset: ck_t  in  1  clock, all logic on posedge; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have request ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-006 SHALL have request fields: req_write in 1 (1=WR, 0=RD); req_bg in BGWIDTH; req_ba in BAWIDTH; req_row in ADDRWIDTH; req_col in COLWIDTH.
REQ-007 SHALL have refresh ports: ref_req  in  1  external refresh request pulse; ref_done  out  1  one-cycle pulse when REF issued.
REQ-008 SHALL drive DIMM pins: cke out 1; cs_n out 1; act_n out 1; addr out ADDRWIDTH; ba out BAWIDTH; bg out BGWIDTH.

Function
REQ-009 All DIMM pin outputs SHALL be registered; at most one command per cycle.
REQ-010 NOP (no command) SHALL drive cs_n=1, act_n=1, addr=0, ba=0, bg=0.
REQ-011 ACT SHALL drive cs_n=0, act_n=0, addr=row, ba/bg=target.
REQ-012 Non-ACT commands SHALL drive cs_n=0, act_n=1, addr[ADDRWIDTH-1:ADDRWIDTH-4]=code: PRE 3, RD 4, REF 5, WR 6; addr[COLWIDTH-1:0]=column for RD/WR, else 0.
REQ-013 Precharge-all SHALL be PRE code 3 with addr[10]=1; single-bank PRE has addr[10]=0.
REQ-014 SHALL keep per-bank table: open bit plus open row, indexed {bg,ba}.
REQ-015 FSM states: IDLE, PRE, TRP_WAIT, ACT, TRCD_WAIT, CAS, PRA, REF, TRFC_WAIT.
REQ-016 req_ready SHALL be 1 only in IDLE with no refresh pending; request fields latched on handshake.
REQ-017 Latched request: row hit -> CAS next cycle; bank closed -> ACT; bank open other row -> PRE.
REQ-018 PRE -> TRP_WAIT for TRP cycles -> ACT; ACT marks bank open with row -> TRCD_WAIT for TRCD cycles -> CAS.
REQ-019 Wait counters SHALL load N-1 on entry and exit when zero, so next command issues exactly N cycles after the prior one.
REQ-020 CAS SHALL issue RD or WR per req_write, then return to IDLE; row stays open.
REQ-021 Refresh pending flag SHALL set on ref_req, clear when REF issues; ref_req while pending is absorbed (no counting).
REQ-022 In IDLE, pending refresh SHALL take priority over req_valid.
REQ-023 Refresh: if any bank open -> PRA, TRP_WAIT, REF; else REF directly; REF clears all open bits, pulses ref_done, then TRFC_WAIT for TRFC cycles -> IDLE.
REQ-024 ref_req during an in-flight request SHALL NOT abort it; refresh follows after CAS.
REQ-025 cke SHALL be 1 whenever out of reset.

Reset
REQ-026 On reset_n low: state IDLE, cke=0, outputs at NOP, req_ready=0, ref_done=0, table cleared, counters 0, pending flag 0.
REQ-027 Reset mid-sequence SHALL abandon the command immediately; first cycle after release drives cke=1 and req_ready=1.

Configuration
REQ-028 Macro AUTO_REFRESH_EN: when defined, internal counter SHALL set refresh pending every TREFI cycles, ORed with ref_req.
REQ-029 Without AUTO_REFRESH_EN: no counter is built; refresh only from ref_req.

Verification
REQ-030 Closed bank 0, read row 5 col 7 -> ACT(row 5) at t, RD(code 4, col 7) at t+TRCD=t+4.
REQ-031 Then read bank 0 row 5 col 9 -> RD issued the cycle after CAS state entry, no ACT/PRE.
REQ-032 Then write bank 0 row 6 -> PRE(addr[10]=0) at t, ACT(row 6) at t+4, WR(code 6) at t+8.
REQ-033 ref_req with bank 0 open and req_valid high -> PRA(addr[10]=1), REF 4 cycles later, ref_done pulse, req_ready 0 until TRFC=16 cycles after REF.
REQ-034 reset_n low during TRCD_WAIT -> next cycle NOP, cke=0; after release a hit-row request issues ACT (table cleared).
REQ-035 AUTO_REFRESH_EN with TREFI=1024, idle -> REF every 1024 cycles; undefined -> no REF without ref_req.
